// File: rtl/sys_arr_arbiter.sv
// sys_arr_arbiter: round-robin job arbiter that shares one sys_array among NREQ
// requesters. It grants one requester per job, routes that requester's operand
// beats into the array and exactly one job's result beats back, and then holds
// the array in soft reset for RST_CYC cycles between jobs.
// Optional feature: define SYS_ARR_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a stalled job with a job_err pulse after TIMEOUT idle cycles.
module sys_arr_arbiter #(
  parameter int unsigned M       = 2,
  parameter int unsigned N       = 2,
  parameter int unsigned K       = 2,
  parameter int unsigned BW      = 2,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        job_done,
  output logic [NREQ-1:0]        job_err,
  output logic                   busy,
  input  logic [NREQ-1:0]        req_in_valid,
  output logic [NREQ-1:0]        req_in_ready,
  input  logic [NREQ*32*BW-1:0]  req_in_stream,
  output logic [NREQ-1:0]        resp_out_valid,
  input  logic [NREQ-1:0]        resp_out_ready,
  output logic [32*BW-1:0]       resp_out_stream,
  output logic                   arr_in_valid,
  input  logic                   arr_in_ready,
  output logic [32*BW-1:0]       arr_in_stream,
  input  logic                   arr_out_valid,
  output logic                   arr_out_ready,
  input  logic [32*BW-1:0]       arr_out_stream,
  output logic                   arr_nrst
);

  localparam int unsigned DW        = 32 * BW;
  localparam int unsigned IN_BEATS  = (M * N + K * N) / BW;
  localparam int unsigned OUT_BEATS = (M * K) / BW;
  localparam int unsigned CIW       = $clog2(IN_BEATS + 1);
  localparam int unsigned COW       = $clog2(OUT_BEATS + 1);
  localparam int unsigned RW        = $clog2(RST_CYC + 1);
  localparam int unsigned LW        = $clog2(NREQ);

  localparam logic [CIW-1:0] IN_LAST  = CIW'(IN_BEATS - 1);
  localparam logic [COW-1:0] OUT_LAST = COW'(OUT_BEATS - 1);
  localparam logic [RW-1:0]  RST_LAST = RW'(RST_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [LW-1:0]   last_q, last_d;
  logic [CIW-1:0]  in_cnt_q, in_cnt_d;
  logic [COW-1:0]  out_cnt_q, out_cnt_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [NREQ-1:0] job_done_q, job_done_d;
  logic [LW-1:0]   win_idx;
  logic            win_found;
  logic            in_hs;
  logic            out_hs;

  // last_q doubles as the owner index for the whole job, since it is set at grant time.
  assign in_hs  = (state_q == LOAD) && req_in_valid[last_q] && arr_in_ready;
  assign out_hs = (state_q == COMPUTE) && arr_out_valid && resp_out_ready[last_q];

  assign grant    = grant_q;
  assign job_done = job_done_q;
  assign busy     = (state_q != IDLE);
  assign arr_nrst = nrst & (state_q != FLUSH);

  // Round-robin search: first asserted request after last_q, cyclically.
  always_comb begin
    win_idx   = last_q;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!win_found && req[LW'((32'(last_q) + i) % NREQ)]) begin
        win_idx   = LW'((32'(last_q) + i) % NREQ);
        win_found = 1'b1;
      end
    end
  end

  // Combinational stream routing between the owner and the array.
  always_comb begin
    arr_in_valid    = 1'b0;
    req_in_ready    = '0;
    arr_out_ready   = 1'b0;
    resp_out_valid  = '0;
    arr_in_stream   = req_in_stream[32'(last_q) * DW +: DW];
    resp_out_stream = arr_out_stream;
    unique case (state_q)
      LOAD: begin
        arr_in_valid         = req_in_valid[last_q];
        req_in_ready[last_q] = arr_in_ready;
      end
      COMPUTE: begin
        resp_out_valid[last_q] = arr_out_valid;
        arr_out_ready          = resp_out_ready[last_q];
      end
      default: ;
    endcase
  end

`ifdef SYS_ARR_ARB_TIMEOUT_EN
  localparam int unsigned   WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0]   wdog_q, wdog_d;
  logic [NREQ-1:0] job_err_q, job_err_d;

  assign job_err = job_err_q;
`else
  assign job_err = '0;
`endif

  // Next-state logic: arbitration, beat counting, flush timing.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    job_done_d = '0;
`ifdef SYS_ARR_ARB_TIMEOUT_EN
    job_err_d  = '0;
    wdog_d     = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = NREQ'(1) << win_idx;
          last_d    = win_idx;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          rst_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (in_hs) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_LAST) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (out_hs) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == OUT_LAST) begin
            job_done_d = grant_q;
            state_d    = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (rst_cnt_q == RST_LAST) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SYS_ARR_ARB_TIMEOUT_EN
    // Watchdog overrides the normal transition when no handshake arrives in time.
    if (state_q == LOAD || state_q == COMPUTE) begin
      if (in_hs || out_hs) begin
        wdog_d = '0;
      end else if (wdog_q == WD_LAST) begin
        job_err_d = grant_q;
        state_d   = FLUSH;
        rst_cnt_d = '0;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  // Main state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= LW'(NREQ - 1);
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rst_cnt_q  <= '0;
      job_done_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      job_done_q <= job_done_d;
    end
  end

`ifdef SYS_ARR_ARB_TIMEOUT_EN
  // Watchdog counter and abort pulse registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wdog_q    <= '0;
      job_err_q <= '0;
    end else begin
      wdog_q    <= wdog_d;
      job_err_q <= job_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_sys_arr_arbiter.sv
// Testbench for sys_arr_arbiter: random-data jobs checked cycle by cycle against
// a job-level reference (round-robin owner choice, beat counts, flush length).
module tb_sys_arr_arbiter;

  localparam int unsigned M         = 2;
  localparam int unsigned N         = 2;
  localparam int unsigned K         = 2;
  localparam int unsigned BW        = 2;
  localparam int unsigned NREQ      = 2;
  localparam int unsigned RST_CYC   = 2;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned DW        = 32 * BW;
  localparam int unsigned IN_BEATS  = (M * N + K * N) / BW;
  localparam int unsigned OUT_BEATS = (M * K) / BW;
  localparam logic [NREQ-1:0] ZERO  = '0;

  logic                  clk;
  logic                  nrst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       job_done;
  logic [NREQ-1:0]       job_err;
  logic                  busy;
  logic [NREQ-1:0]       req_in_valid;
  logic [NREQ-1:0]       req_in_ready;
  logic [NREQ*DW-1:0]    req_in_stream;
  logic [NREQ-1:0]       resp_out_valid;
  logic [NREQ-1:0]       resp_out_ready;
  logic [DW-1:0]         resp_out_stream;
  logic                  arr_in_valid;
  logic                  arr_in_ready;
  logic [DW-1:0]         arr_in_stream;
  logic                  arr_out_valid;
  logic                  arr_out_ready;
  logic [DW-1:0]         arr_out_stream;
  logic                  arr_nrst;

  int unsigned passes = 0;
  int unsigned fails  = 0;
  int unsigned total  = 0;
  int unsigned last_owner;
  int unsigned own;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  sys_arr_arbiter #(
    .M(M), .N(N), .K(K), .BW(BW), .NREQ(NREQ), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nrst(nrst), .req(req), .grant(grant), .job_done(job_done),
    .job_err(job_err), .busy(busy),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready), .req_in_stream(req_in_stream),
    .resp_out_valid(resp_out_valid), .resp_out_ready(resp_out_ready),
    .resp_out_stream(resp_out_stream),
    .arr_in_valid(arr_in_valid), .arr_in_ready(arr_in_ready), .arr_in_stream(arr_in_stream),
    .arr_out_valid(arr_out_valid), .arr_out_ready(arr_out_ready),
    .arr_out_stream(arr_out_stream), .arr_nrst(arr_nrst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration: first requester after `last`, searching cyclically.
  function automatic int unsigned rr_next(input logic [NREQ-1:0] r, input int unsigned last);
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return last;
  endfunction

  function automatic logic [NREQ-1:0] omask(input int unsigned o);
    logic [NREQ-1:0] m;
    m = '0;
    m[o] = 1'b1;
    return m;
  endfunction

  task automatic rand_inputs();
    req_in_valid = NREQ'($urandom);
    for (int i = 0; i < int'(NREQ); i++) req_in_stream[i*DW +: DW] = {$urandom, $urandom};
    arr_in_ready   = 1'($urandom);
    arr_out_valid  = 1'($urandom);
    arr_out_stream = {$urandom, $urandom};
    resp_out_ready = NREQ'($urandom);
  endtask

  task automatic check_reset_vals();
    chk("rst_grant", grant, ZERO);
    chk("rst_done", job_done, ZERO);
    chk("rst_err", job_err, ZERO);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", req_in_ready, ZERO);
    chk("rst_rvalid", resp_out_valid, ZERO);
    chk("rst_avalid", arr_in_valid, 1'b0);
    chk("rst_aready", arr_out_ready, 1'b0);
    chk("rst_arr_nrst", arr_nrst, 1'b0);
  endtask

  // One IDLE cycle; entered at posedge+1 with req already driven.
  task automatic do_idle();
    rand_inputs();
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_grant", grant, ZERO);
    chk("idle_rdy", req_in_ready, ZERO);
    chk("idle_rvalid", resp_out_valid, ZERO);
    chk("idle_avalid", arr_in_valid, 1'b0);
    chk("idle_aready", arr_out_ready, 1'b0);
    chk("idle_arr_nrst", arr_nrst, 1'b1);
    chk("idle_err", job_err, ZERO);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int unsigned owner, input bit bp);
    logic [DW-1:0]   op [IN_BEATS];
    logic [NREQ-1:0] gm;
    int unsigned     nin;
    int unsigned     cyc;
    gm  = omask(owner);
    nin = 0;
    cyc = 0;
    foreach (op[i]) op[i] = {$urandom, $urandom};
    while (nin < IN_BEATS && cyc < 200) begin
      rand_inputs();
      req_in_stream[owner*DW +: DW] = op[nin];
      if (bp) begin
        req_in_valid[owner] = 1'b1;
        arr_in_ready        = (cyc % 2 == 1);
      end
      @(negedge clk);
      chk("load_grant", grant, gm);
      chk("load_busy", busy, 1'b1);
      chk("load_avalid", arr_in_valid, req_in_valid[owner]);
      chk("load_rdy", req_in_ready, arr_in_ready ? gm : ZERO);
      chk("load_data", arr_in_stream, op[nin]);
      chk("load_aready", arr_out_ready, 1'b0);
      chk("load_rvalid", resp_out_valid, ZERO);
      chk("load_done", job_done, ZERO);
      chk("load_err", job_err, ZERO);
      chk("load_arr_nrst", arr_nrst, 1'b1);
      if (req_in_valid[owner] && arr_in_ready) nin++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("load_beats", nin, IN_BEATS);
  endtask

  task automatic do_compute(input int unsigned owner, input bit bp);
    logic [DW-1:0]   res [OUT_BEATS];
    logic [NREQ-1:0] gm;
    int unsigned     nout;
    int unsigned     cyc;
    int unsigned     hold;
    gm   = omask(owner);
    nout = 0;
    cyc  = 0;
    hold = 0;
    foreach (res[i]) res[i] = {$urandom, $urandom};
    while (nout < OUT_BEATS && cyc < 400) begin
      rand_inputs();
      arr_out_stream = res[nout];
      if (bp) begin
        arr_out_valid         = 1'b1;
        resp_out_ready[owner] = (hold >= 5);
      end
      @(negedge clk);
      chk("cmp_grant", grant, gm);
      chk("cmp_busy", busy, 1'b1);
      chk("cmp_rvalid", resp_out_valid, arr_out_valid ? gm : ZERO);
      chk("cmp_aready", arr_out_ready, resp_out_ready[owner]);
      chk("cmp_data", resp_out_stream, res[nout]);
      chk("cmp_rdy", req_in_ready, ZERO);
      chk("cmp_avalid", arr_in_valid, 1'b0);
      chk("cmp_done", job_done, ZERO);
      chk("cmp_err", job_err, ZERO);
      if (arr_out_valid && resp_out_ready[owner]) begin
        nout++;
        hold = 0;
      end else begin
        hold++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("cmp_beats", nout, OUT_BEATS);
  endtask

  // RST_CYC flush cycles with every input trying to push traffic through.
  task automatic do_flush(input int unsigned owner, input bit err);
    logic [NREQ-1:0] gm;
    gm = omask(owner);
    for (int unsigned k = 0; k < RST_CYC; k++) begin
      rand_inputs();
      arr_out_valid  = 1'b1;
      resp_out_ready = '1;
      req_in_valid   = '1;
      arr_in_ready   = 1'b1;
      @(negedge clk);
      chk("fl_done", job_done, (k == 0 && !err) ? gm : ZERO);
      chk("fl_err", job_err, (k == 0 && err) ? gm : ZERO);
      chk("fl_arr_nrst", arr_nrst, 1'b0);
      chk("fl_busy", busy, 1'b1);
      chk("fl_grant", grant, gm);
      chk("fl_aready", arr_out_ready, 1'b0);
      chk("fl_avalid", arr_in_valid, 1'b0);
      chk("fl_rdy", req_in_ready, ZERO);
      chk("fl_rvalid", resp_out_valid, ZERO);
      @(posedge clk); #1;
    end
  endtask

  task automatic full_job(input bit bp);
    own = rr_next(req, last_owner);
    last_owner = own;
    do_idle();
    do_load(own, bp);
    do_compute(own, bp);
    do_flush(own, 1'b0);
  endtask

  initial begin
    nrst = 1'b0;
    req  = '0;
    last_owner = NREQ - 1;
    rand_inputs();
    req_in_valid = '1;
    arr_in_ready = 1'b1;
    arr_out_valid = 1'b1;
    resp_out_ready = '1;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;

    // Contention from reset: both held high, expect owners 0,1,0,1.
    req  = 2'b11;
    nrst = 1'b1;
    for (int j = 0; j < 4; j++) full_job(1'b0);
    req = '0;

    // Single job for requester 0, then an idle cycle with nothing pending.
    req = 2'b01;
    full_job(1'b0);
    req = '0;
    do_idle();

    // Backpressure job for requester 1.
    req = 2'b10;
    full_job(1'b1);
    req = '0;
    do_idle();

    // Reset after two operand beats, then a clean job from the reset owner order.
    req = 2'b01;
    own = rr_next(req, last_owner);
    last_owner = own;
    do_idle();
    for (int b = 0; b < 2; b++) begin
      rand_inputs();
      req_in_valid[own] = 1'b1;
      arr_in_ready      = 1'b1;
      @(negedge clk);
      chk("mid_rdy", req_in_ready, omask(own));
      @(posedge clk); #1;
    end
    req_in_valid   = '1;
    arr_in_ready   = 1'b1;
    arr_out_valid  = 1'b1;
    resp_out_ready = '1;
    nrst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    nrst = 1'b1;
    last_owner = NREQ - 1;
    full_job(1'b0);
    req = '0;
    do_idle();

    // Array never produces results after a full operand load.
    req = 2'b11;
    own = rr_next(req, last_owner);
    last_owner = own;
    do_idle();
    do_load(own, 1'b0);
`ifdef SYS_ARR_ARB_TIMEOUT_EN
    for (int c = 0; c < int'(TIMEOUT); c++) begin
      rand_inputs();
      arr_out_valid = 1'b0;
      @(negedge clk);
      chk("wd_wait_err", job_err, ZERO);
      chk("wd_wait_busy", arr_nrst, 1'b1);
      @(posedge clk); #1;
    end
    do_flush(own, 1'b1);
    full_job(1'b0);
    req = '0;
    do_idle();
`else
    for (int c = 0; c < 40; c++) begin
      rand_inputs();
      arr_out_valid = 1'b0;
      @(negedge clk);
      chk("stall_busy", busy, 1'b1);
      chk("stall_grant", grant, omask(own));
      chk("stall_err", job_err, ZERO);
      chk("stall_arr_nrst", arr_nrst, 1'b1);
      @(posedge clk); #1;
    end
    req  = '0;
    nrst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    nrst = 1'b1;
    last_owner = NREQ - 1;
    do_idle();
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
